// File: rtl/aqed_fifo_checker.sv
// A-QED functional-consistency and response-bound checker for a FIFO-mode memory core.
// Tags an original write and a matching duplicate write by stream position, then compares their outputs.
module aqed_fifo_checker #(
  parameter int DATA_WIDTH  = 16,
  parameter int CNT_WIDTH   = 17,
  parameter int DEPTH_WIDTH = 16,
  parameter int BOUND_MULT  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   flush,
  input  logic [DEPTH_WIDTH-1:0] depth,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   orig_sel,
  input  logic                   dup_sel,
  output logic                   in_ready,
  input  logic                   out_ready,
  output logic                   dut_wen,
  output logic [DATA_WIDTH-1:0]  dut_data_in,
  output logic                   dut_ren,
  input  logic                   dut_full,
  input  logic                   dut_valid,
  input  logic [DATA_WIDTH-1:0]  dut_data_out,
  output logic                   orig_issued,
  output logic                   orig_done,
  output logic                   qed_done,
  output logic                   qed_check,
  output logic                   bound_fail
);
  localparam int PW = DEPTH_WIDTH + $clog2(BOUND_MULT);
  localparam int CW = (PW > CNT_WIDTH) ? PW : CNT_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT_DUP, WAIT_OUT, DONE} state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_in_cnt, r_out_cnt, r_orig_idx, r_dup_idx, r_rd_after;
  logic [DATA_WIDTH-1:0] r_orig_data, r_orig_out, r_dup_out;
  logic                  r_orig_issued, r_orig_out_seen, r_dup_out_seen;
  logic                  r_qed_done, r_qed_check, r_bound_fail;

  logic                  w_wen_acc, w_rd_acc, w_in_sat, w_out_sat, w_dup_valid;
  logic                  w_orig_cap, w_dup_cap, w_rd_cnt_en, w_bound_hit;
  logic [CNT_WIDTH-1:0]  w_rd_nxt;
  logic [PW-1:0]         w_bound;

  assign in_ready    = ~dut_full;
  assign dut_wen     = in_valid & in_ready & clk_en;
  assign dut_data_in = in_data;
  assign dut_ren     = out_ready & clk_en;

  assign w_wen_acc   = dut_wen;
  assign w_rd_acc    = dut_ren & dut_valid;
  assign w_in_sat    = &r_in_cnt;
  assign w_out_sat   = &r_out_cnt;
  // dup_idx is only meaningful once the duplicate has been tagged
  assign w_dup_valid = (r_state == WAIT_OUT) || (r_state == DONE);

  assign w_orig_cap  = w_rd_acc & ~w_out_sat & r_orig_issued & ~r_orig_out_seen &
                       (r_out_cnt == r_orig_idx);
  assign w_dup_cap   = w_rd_acc & ~w_out_sat & w_dup_valid & ~r_dup_out_seen &
                       (r_out_cnt == r_dup_idx);

  assign w_rd_cnt_en = w_rd_acc & r_orig_issued & ~r_orig_out_seen;
  assign w_rd_nxt    = (w_rd_cnt_en && !(&r_rd_after)) ? r_rd_after + CNT_WIDTH'(1) : r_rd_after;
  assign w_bound     = PW'(depth) * PW'(BOUND_MULT);
  // Compare against the post-increment count so the flag rises on the read that reaches the bound
  assign w_bound_hit = r_orig_issued & ~(r_orig_out_seen | w_orig_cap) &
                       (CW'(w_rd_nxt) >= CW'(w_bound));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_in_cnt <= '0; r_out_cnt <= '0; r_orig_idx <= '0; r_dup_idx <= '0; r_rd_after <= '0;
      r_orig_data <= '0; r_orig_out <= '0; r_dup_out <= '0;
      r_orig_issued <= 1'b0; r_orig_out_seen <= 1'b0; r_dup_out_seen <= 1'b0;
      r_qed_done <= 1'b0; r_qed_check <= 1'b0; r_bound_fail <= 1'b0;
    end else if (flush) begin
      r_state <= IDLE;
      r_in_cnt <= '0; r_out_cnt <= '0; r_orig_idx <= '0; r_dup_idx <= '0; r_rd_after <= '0;
      r_orig_data <= '0; r_orig_out <= '0; r_dup_out <= '0;
      r_orig_issued <= 1'b0; r_orig_out_seen <= 1'b0; r_dup_out_seen <= 1'b0;
      r_qed_done <= 1'b0; r_qed_check <= 1'b0; r_bound_fail <= 1'b0;
    end else if (clk_en) begin
      if (w_wen_acc && !w_in_sat) r_in_cnt  <= r_in_cnt + CNT_WIDTH'(1);
      if (w_rd_acc && !w_out_sat) r_out_cnt <= r_out_cnt + CNT_WIDTH'(1);
      r_rd_after <= w_rd_nxt;
      if (w_bound_hit) r_bound_fail <= 1'b1;
      if (w_orig_cap) begin
        r_orig_out      <= dut_data_out;
        r_orig_out_seen <= 1'b1;
      end
      if (w_dup_cap) begin
        r_dup_out      <= dut_data_out;
        r_dup_out_seen <= 1'b1;
      end
      case (r_state)
        IDLE: if (w_wen_acc && orig_sel) begin
          r_orig_idx    <= r_in_cnt;
          r_orig_data   <= in_data;
          r_orig_issued <= 1'b1;
          r_state       <= WAIT_DUP;
        end
        WAIT_DUP: if (w_wen_acc && dup_sel && (in_data == r_orig_data)) begin
          r_dup_idx <= r_in_cnt;
          r_state   <= WAIT_OUT;
        end
        WAIT_OUT: if (r_orig_out_seen && r_dup_out_seen) begin
          r_state     <= DONE;
          r_qed_done  <= 1'b1;
          r_qed_check <= (r_orig_out == r_dup_out);
        end
        default: ;
      endcase
    end
  end

  assign orig_issued = r_orig_issued;
  assign orig_done   = r_orig_out_seen;
  assign qed_done    = r_qed_done;
  assign qed_check   = r_qed_check;
  assign bound_fail  = r_bound_fail;
endmodule

// File: tb/tb_aqed_fifo_checker.sv
module tb_aqed_fifo_checker;
  logic        clk = 1'b0;
  logic        reset, clk_en, flush;
  logic [15:0] depth;
  logic        in_valid, orig_sel, dup_sel, out_ready, dut_full;
  logic [15:0] in_data;
  logic        in_ready, dut_wen, dut_ren, dut_valid;
  logic [15:0] dut_data_in, dut_data_out;
  logic        orig_issued, orig_done, qed_done, qed_check, bound_fail;

  int n_cmp = 0;
  int n_mis = 0;

  logic [15:0] mem [0:63];
  int          wp = 0, rp = 0;
  int          corrupt_pos = -1;
  logic        mdl_clr = 1'b0;

  bit          exp_chk_q[$];
  logic [15:0] exp_wd_q[$];

  aqed_fifo_checker dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .depth(depth),
    .in_valid(in_valid), .in_data(in_data), .orig_sel(orig_sel), .dup_sel(dup_sel),
    .in_ready(in_ready), .out_ready(out_ready), .dut_wen(dut_wen), .dut_data_in(dut_data_in),
    .dut_ren(dut_ren), .dut_full(dut_full), .dut_valid(dut_valid), .dut_data_out(dut_data_out),
    .orig_issued(orig_issued), .orig_done(orig_done), .qed_done(qed_done),
    .qed_check(qed_check), .bound_fail(bound_fail)
  );

  always #5 clk = ~clk;

  assign dut_valid    = (wp != rp);
  assign dut_data_out = (rp == corrupt_pos) ? 16'h00FF : mem[rp[5:0]];

  always @(posedge clk) begin
    if (mdl_clr) begin
      wp <= 0;
      rp <= 0;
    end else begin
      if (dut_wen) begin
        mem[wp[5:0]] <= dut_data_in;
        wp <= wp + 1;
      end
      if (dut_ren && dut_valid) rp <= rp + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] d, input bit o, input bit u);
    in_valid = 1'b1; in_data = d; orig_sel = o; dup_sel = u;
    exp_wd_q.push_back(d);
    #1;
    chk("wr_forward_en", 32'(dut_wen), 32'(1'b1));
    chk("wr_forward_data", 32'(dut_data_in), 32'(exp_wd_q.pop_front()));
    step();
    in_valid = 1'b0; orig_sel = 1'b0; dup_sel = 1'b0;
  endtask

  task automatic rd(input int n);
    for (int i = 0; i < n; i++) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic restart();
    flush = 1'b1; mdl_clr = 1'b1;
    step();
    flush = 1'b0; mdl_clr = 1'b0;
  endtask

  task automatic chk_done(input string tag);
    bit exp_c;
    for (int i = 0; i < 4 && !qed_done; i++) step();
    chk({tag, "_done"}, 32'(qed_done), 32'(1'b1));
    exp_c = (exp_chk_q.size() != 0) ? exp_chk_q.pop_front() : 1'b1;
    chk({tag, "_check"}, 32'(qed_check), 32'(exp_c));
  endtask

  initial begin
    reset = 1'b0; clk_en = 1'b1; flush = 1'b0; depth = 16'd4;
    in_valid = 1'b0; in_data = '0; orig_sel = 1'b0; dup_sel = 1'b0;
    out_ready = 1'b0; dut_full = 1'b0;
    mdl_clr = 1'b1;
    #12;
    chk("rst_orig_issued", 32'(orig_issued), 32'(1'b0));
    chk("rst_qed_done", 32'(qed_done), 32'(1'b0));
    chk("rst_bound_fail", 32'(bound_fail), 32'(1'b0));
    chk("rst_in_ready", 32'(in_ready), 32'(1'b1));
    reset = 1'b1;
    step();
    mdl_clr = 1'b0;

    wr(16'd1, 0, 0);
    chk("s1_no_issue_yet", 32'(orig_issued), 32'(1'b0));
    wr(16'd2, 1, 0);
    chk("s1_orig_issued", 32'(orig_issued), 32'(1'b1));
    wr(16'd3, 0, 0);
    wr(16'd2, 0, 1);
    exp_chk_q.push_back(1'b1);
    rd(2);
    chk("s1_orig_done", 32'(orig_done), 32'(1'b1));
    rd(2);
    chk("s1_done_latency", 32'(qed_done), 32'(1'b0));
    step();
    chk("s1_done_next", 32'(qed_done), 32'(1'b1));
    chk_done("s1");
    chk("s1_bound", 32'(bound_fail), 32'(1'b0));

    restart();
    chk("flush_clear_done", 32'(qed_done), 32'(1'b0));
    wr(16'd1, 0, 0); wr(16'd2, 1, 0); wr(16'd3, 0, 0); wr(16'd2, 0, 1);
    exp_chk_q.push_back(1'b0);
    corrupt_pos = 3;
    rd(4);
    corrupt_pos = -1;
    chk_done("s2");

    restart();
    depth = 16'd2;
    for (int i = 0; i < 10; i++) wr(16'(16'h10 + i), 0, 0);
    wr(16'h00AA, 1, 0);
    rd(7);
    chk("s3_bound_7", 32'(bound_fail), 32'(1'b0));
    rd(1);
    chk("s3_bound_8", 32'(bound_fail), 32'(1'b1));
    rd(3);
    chk("s3_orig_done", 32'(orig_done), 32'(1'b1));
    chk("s3_bound_sticky", 32'(bound_fail), 32'(1'b1));

    restart();
    chk("flush_clear_bound", 32'(bound_fail), 32'(1'b0));
    depth = 16'd4;
    wr(16'd5, 1, 0);
    wr(16'd6, 0, 1);
    wr(16'd5, 0, 1);
    exp_chk_q.push_back(1'b1);
    rd(3);
    chk_done("s4");

    restart();
    dut_full = 1'b1; in_valid = 1'b1; in_data = 16'd7; orig_sel = 1'b1;
    #1;
    chk("s5_full_ready", 32'(in_ready), 32'(1'b0));
    chk("s5_full_wen", 32'(dut_wen), 32'(1'b0));
    step();
    chk("s5_full_issue", 32'(orig_issued), 32'(1'b0));
    dut_full = 1'b0; clk_en = 1'b0; out_ready = 1'b1;
    #1;
    chk("s5_ce_wen", 32'(dut_wen), 32'(1'b0));
    chk("s5_ce_ren", 32'(dut_ren), 32'(1'b0));
    step();
    chk("s5_ce_issue", 32'(orig_issued), 32'(1'b0));
    clk_en = 1'b1; out_ready = 1'b0; in_valid = 1'b0; orig_sel = 1'b0;
    wr(16'd8, 1, 0);
    wr(16'd8, 0, 1);
    exp_chk_q.push_back(1'b1);
    rd(2);
    chk_done("s5");

    restart();
    wr(16'd1, 1, 0);
    wr(16'd1, 0, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("s6_rst_issue", 32'(orig_issued), 32'(1'b0));
    chk("s6_rst_done", 32'(orig_done), 32'(1'b0));
    reset = 1'b1;
    restart();
    wr(16'd3, 1, 0);
    wr(16'd3, 0, 1);
    exp_chk_q.push_back(1'b1);
    rd(2);
    chk_done("s6");
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("s6_flush_done", 32'(qed_done), 32'(1'b0));
    chk("s6_flush_check", 32'(qed_check), 32'(1'b0));
    chk("s6_flush_issue", 32'(orig_issued), 32'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
